// File: rtl/pcseq_pkg.sv
// Shared types and defaults for the fetch-stage program-counter sequencer.
package pcseq_pkg;

    localparam int PCSEQ_PC_W   = 16;
    localparam int PC_INC_DEF   = 1;

    typedef logic [PCSEQ_PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_RET
    } pc_src_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry
// and raises a sticky overflow flag; the entry count saturates at DEPTH.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] top_idx;
    logic [AW:0]   count;

    // ptr addresses the next free slot; it wraps, count does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + AW'(1);
            if (count == FULL) begin
                ovf <= 1'b1;
            end else begin
                count <= count + (AW+1)'(1);
            end
        end else if (pop) begin
            ptr   <= ptr - AW'(1);
            count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    assign top_idx = ptr - AW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with prioritised next-PC select (ret > call/jump > branch > seq).
// Define PCSEQ_RAS_EN to build in the return-address stack for call/ret.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int RESET_PC  = 0,
    parameter int PC_INC    = PC_INC_DEF,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output logic            ras_empty,
    output logic            ras_ovf
);

    localparam logic [PC_W-1:0] INC   = PC_W'(PC_INC);
    localparam logic [PC_W-1:0] RST_V = PC_W'(RESET_PC);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
    end

    logic [PC_W-1:0] pc_seq;
    pc_src_e         src;

    assign pc_seq = pc + INC;

`ifdef PCSEQ_RAS_EN
    logic            push;
    logic            pop;
    logic            st_empty;
    logic            st_ovf;
    logic [PC_W-1:0] ras_top;

    // ret outranks call, so a simultaneous call never pushes
    assign pop  = ret && !stall && !st_empty;
    assign push = call && !ret && !stall;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_seq),
        .top   (ras_top),
        .empty (st_empty),
        .ovf   (st_ovf)
    );

    assign ras_empty = st_empty;
    assign ras_ovf   = st_ovf;
`else
    assign ras_empty = 1'b1;
    assign ras_ovf   = 1'b0;
`endif

    always_comb begin
        src     = SRC_SEQ;
        next_pc = pc_seq;
`ifdef PCSEQ_RAS_EN
        if (ret && !st_empty) begin
            src     = SRC_RET;
            next_pc = ras_top;
        end else
`endif
        // ret with nothing to return to falls back to jump_target
        if (ret || call || jump) begin
            src     = SRC_JUMP;
            next_pc = jump_target;
        end else if (branch_taken) begin
            src     = SRC_BRANCH;
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RST_V;
            redirect <= 1'b0;
        end else if (!stall) begin
            pc       <= next_pc;
            redirect <= (src != SRC_SEQ);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomised bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

    localparam int PC_W      = 16;
    localparam int PC_INC    = 1;
    localparam int RAS_DEPTH = 4;
`ifdef PCSEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic            branch_taken = 1'b0;
    logic [PC_W-1:0] branch_target = '0;
    logic            jump = 1'b0;
    logic [PC_W-1:0] jump_target = '0;
    logic            call = 1'b0;
    logic            ret = 1'b0;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            redirect;
    logic            ras_empty;
    logic            ras_ovf;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [PC_W-1:0] m_pc;
    logic            m_red;
    logic            m_ovf;
    logic [PC_W-1:0] m_q[$];

    pc_sequencer #(
        .PC_W      (PC_W),
        .RESET_PC  (0),
        .PC_INC    (PC_INC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc            (pc),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .ras_empty     (ras_empty),
        .ras_ovf       (ras_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [PC_W-1:0] obs, input logic [PC_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_red = 1'b0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    function automatic logic [PC_W-1:0] model_next();
        if (ret && RAS && m_q.size() > 0) return m_q[m_q.size()-1];
        if (ret || call || jump) return jump_target;
        if (branch_taken) return branch_target;
        return m_pc + PC_W'(PC_INC);
    endfunction

    task automatic model_edge();
        logic [PC_W-1:0] nx;
        nx = model_next();
        if (stall) return;
        m_red = ret || call || jump || branch_taken;
        if (ret) begin
            if (RAS && m_q.size() > 0) void'(m_q.pop_back());
        end else if (call && RAS) begin
            if (m_q.size() == RAS_DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            m_q.push_back(m_pc + PC_W'(PC_INC));
        end
        m_pc = nx;
    endtask

    task automatic idle();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    // check next_pc before the edge, registered outputs just after it
    task automatic step(input string tag);
        #1;
        check({tag, "_next"}, next_pc, model_next());
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_redir"}, PC_W'(redirect), PC_W'(m_red));
        check({tag, "_empty"}, PC_W'(ras_empty), PC_W'(m_q.size() == 0));
        check({tag, "_ovf"}, PC_W'(ras_ovf), PC_W'(m_ovf));
    endtask

    initial begin
        model_reset();
        // reset state and sequential counting
        #12;
        check("rst_pc", pc, 16'h0000);
        check("rst_redir", PC_W'(redirect), 16'h0);
        check("rst_empty", PC_W'(ras_empty), 16'h1);
        check("rst_ovf", PC_W'(ras_ovf), 16'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step("idle");
            check("idle_seq", pc, PC_W'(i));
        end

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc, 16'h0000);
        check("async_redir", PC_W'(redirect), 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // jump beats branch
        branch_taken = 1'b1; branch_target = 16'h0040;
        jump = 1'b1; jump_target = 16'h1234;
        step("jb");
        check("jb_pc", pc, 16'h1234);
        check("jb_redir", PC_W'(redirect), 16'h1);
        idle();
        step("jb_after");
        check("jb_after_redir", PC_W'(redirect), 16'h0);
        check("jb_after_pc", pc, 16'h1235);

        // stall holds pc and redirect, ignores the jump
        jump = 1'b1; jump_target = 16'h2000;
        step("pre_stall");
        stall = 1'b1; jump_target = 16'h3333;
        for (int i = 0; i < 2; i++) begin
            step("stall");
            check("stall_pc", pc, 16'h2000);
            check("stall_redir", PC_W'(redirect), 16'h1);
        end
        idle();
        step("unstall");
        check("unstall_pc", pc, 16'h2001);
        check("unstall_redir", PC_W'(redirect), 16'h0);

        // wrap at all-ones
        jump = 1'b1; jump_target = 16'hFFFF;
        step("to_ffff");
        idle();
        step("wrap");
        check("wrap_pc", pc, 16'h0000);
        check("wrap_redir", PC_W'(redirect), 16'h0);

`ifdef PCSEQ_RAS_EN
        // single call / return
        jump = 1'b1; jump_target = 16'h0010;
        step("to_10");
        idle();
        check("call_pre_empty", PC_W'(ras_empty), 16'h1);
        call = 1'b1; jump_target = 16'h0100;
        step("call");
        check("call_pc", pc, 16'h0100);
        check("call_empty", PC_W'(ras_empty), 16'h0);
        idle(); ret = 1'b1;
        step("ret");
        check("ret_pc", pc, 16'h0011);
        check("ret_empty", PC_W'(ras_empty), 16'h1);

        // overflow then underflow
        idle(); jump = 1'b1; jump_target = 16'h0500;
        step("to_500");
        idle(); call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jump_target = 16'h1000 + PC_W'(i * 16);
            step("ovf_call");
        end
        check("ovf_flag", PC_W'(ras_ovf), 16'h1);
        idle(); ret = 1'b1; jump_target = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            step("lifo");
            check("lifo_pc", pc, 16'h1031 - PC_W'(k * 16));
        end
        step("uflow");
        check("uflow_pc", pc, 16'hBEEF);
        check("uflow_empty", PC_W'(ras_empty), 16'h1);
        check("uflow_ovf", PC_W'(ras_ovf), 16'h1);
`endif

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 6) == 0);
            call          = ($urandom_range(0, 5) == 0);
            ret           = ($urandom_range(0, 5) == 0);
            branch_target = PC_W'($urandom);
            jump_target   = PC_W'($urandom);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
